// File: rtl/mdr_pkg.sv
// Shared constants and FSM state type for the SQRT result BCD converter.
package mdr_pkg;
  localparam int DW    = 16;  // operand width; only 16 is supported
  localparam int N_DIG = 5;   // BCD digits per operand (65535 / 32768 fit)
  localparam int ITER  = 16;  // double-dabble steps per operand, one per bit

  typedef enum logic [1:0] {
    IDLE,
    CONV_R,
    CONV_M,
    DONE
  } state_e;
endpackage

// File: rtl/bcd_add3_step.sv
// Conditional add-3 on every BCD digit: the adjust half of one double-dabble step.
module bcd_add3_step #(
  parameter int N_DIG = 5
) (
  input  logic [4*N_DIG-1:0] din,
  output logic [4*N_DIG-1:0] dout
);

  for (genvar d = 0; d < N_DIG; d++) begin : g_dig
    logic [3:0] dig;
    assign dig = din[4*d +: 4];
    // A digit of 5..9 becomes >= 10 after the following shift, so pre-bias it.
    assign dout[4*d +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
  end

endmodule

// File: rtl/mdr_result_bcd.sv
// Converts the SQRT root and signed remainder to packed BCD, one operand after
// the other, through a single shared double-dabble shift register.
module mdr_result_bcd #(
  parameter int DW    = mdr_pkg::DW,
  parameter int N_DIG = mdr_pkg::N_DIG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic [DW-1:0]      result,
  input  logic [DW-1:0]      reminder,
  output logic [4*N_DIG-1:0] res_bcd,
  output logic [4*N_DIG-1:0] rem_bcd,
  output logic               rem_neg,
  output logic               busy,
  output logic               valid
);
  import mdr_pkg::*;

  localparam int BW = 4*N_DIG;          // BCD field width
  localparam int SW = BW + DW;          // shift register: BCD above binary
  localparam int CW = $clog2(ITER);

  state_e        state, state_nx;
  logic          ready_q;
  logic          live;                  // low for the first cycle after reset
  logic          sign;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sr;
  logic [DW-1:0] rem_mag;               // remainder magnitude parked for CONV_M
  logic [BW-1:0] res_tmp;               // finished root digits parked until DONE
  logic [BW-1:0] adj;
  logic [SW-1:0] sr_step;
  logic [DW-1:0] rem_abs;
  logic          trig;
  logic          last;

  // A level already high when reset releases must not look like a rising edge,
  // so triggers are blocked until ready_q has sampled ready once.
  assign trig    = ready & ~ready_q & live;
  assign last    = (cnt == CW'(ITER-1));
  assign rem_abs = reminder[DW-1] ? (~reminder) + DW'(1) : reminder;

  bcd_add3_step #(.N_DIG(N_DIG)) u_add3 (
    .din  (sr[SW-1:DW]),
    .dout (adj)
  );

  // Adjusted digits and remaining binary bits shift left together by one.
  assign sr_step = {adj[BW-2:0], sr[DW-1:0], 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state: each conversion phase lasts ITER cycles, DONE lasts one.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (trig) state_nx = CONV_R;
      CONV_R:  if (last) state_nx = CONV_M;
      CONV_M:  if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch operands, run the double-dabble steps, publish in DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      live    <= 1'b0;
      sign    <= 1'b0;
      cnt     <= '0;
      sr      <= '0;
      rem_mag <= '0;
      res_tmp <= '0;
      res_bcd <= '0;
      rem_bcd <= '0;
      rem_neg <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      ready_q <= ready;
      live    <= 1'b1;
      valid   <= 1'b0;
      busy    <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (trig) begin
            sr      <= {{BW{1'b0}}, result};
            rem_mag <= rem_abs;
            sign    <= reminder[DW-1];
            cnt     <= '0;
          end
        end
        CONV_R: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            res_tmp <= sr_step[SW-1:DW];
            sr      <= {{BW{1'b0}}, rem_mag};
          end else begin
            sr <= sr_step;
          end
        end
        CONV_M: begin
          cnt <= cnt + 1'b1;
          sr  <= sr_step;
        end
        DONE: begin
          res_bcd <= res_tmp;
          rem_bcd <= sr[SW-1:DW];
          rem_neg <= sign;
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_result_bcd.sv
// Randomized and directed checks of mdr_result_bcd against a decimal model.
module tb_mdr_result_bcd;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [15:0] result, reminder;
  logic [19:0] res_bcd, rem_bcd;
  logic        rem_neg, busy, valid;

  int checks = 0;
  int errors = 0;
  int pulses;

  logic [19:0] exp_res = '0;
  logic [19:0] exp_rem = '0;
  logic        exp_neg = 1'b0;

  mdr_result_bcd dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .result   (result),
    .reminder (reminder),
    .res_bcd  (res_bcd),
    .rem_bcd  (rem_bcd),
    .rem_neg  (rem_neg),
    .busy     (busy),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Decimal digits by repeated division.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] b;
    b = '0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  task automatic set_exp(input logic [15:0] r, input logic [15:0] m);
    int unsigned mag;
    mag = m[15] ? (32'h10000 - 32'(m)) : 32'(m);
    exp_res = to_bcd(32'(r));
    exp_rem = to_bcd(mag);
    exp_neg = m[15];
  endtask

  task automatic check_outs();
    chk("res_bcd", 32'(res_bcd), 32'(exp_res));
    chk("rem_bcd", 32'(rem_bcd), 32'(exp_rem));
    chk("rem_neg", 32'(rem_neg), 32'(exp_neg));
  endtask

  // One conversion: rising ready, optional input scrambling while busy.
  task automatic do_conv(input logic [15:0] r, input logic [15:0] m, input bit scramble);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(negedge clk);
    result = r; reminder = m; ready = 1'b1;
    set_exp(r, m);
    while (!got && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (valid) got = 1'b1;
      else begin
        if (n == 1) chk("busy_start", 32'(busy), 1);
        if (n == 3) ready = 1'b0;
        if (scramble) begin
          result   = 16'($urandom);
          reminder = 16'($urandom);
        end
      end
    end
    chk("latency", n, 34);
    chk("busy_at_valid", 32'(busy), 0);
    check_outs();
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(valid), 0);
    check_outs();
  endtask

  initial begin
    rst = 1'b0; ready = 1'b0; result = '0; reminder = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outs();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vectors.
    do_conv(16'h00FF, 16'h0003, 1'b0);
    chk("d1_res", 32'(res_bcd), 32'h00255);
    do_conv(16'hFFFF, 16'hFFFB, 1'b1);
    chk("d2_res", 32'(res_bcd), 32'h65535);
    chk("d2_rem", 32'(rem_bcd), 32'h00005);
    do_conv(16'h0000, 16'h8000, 1'b0);
    chk("d3_rem", 32'(rem_bcd), 32'h32768);
    chk("d3_neg", 32'(rem_neg), 1);

    // Random operands, alternating input scrambling during busy.
    for (int k = 0; k < 10; k++)
      do_conv(16'($urandom), 16'($urandom), k[0]);

    // Outputs hold while idle with inputs wandering.
    repeat (5) begin
      @(negedge clk); result = 16'($urandom); reminder = 16'($urandom);
    end
    #1; check_outs();

    // ready held high: exactly one conversion.
    @(negedge clk);
    result = 16'd1234; reminder = 16'hFFFF; ready = 1'b1;
    set_exp(16'd1234, 16'hFFFF);
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    chk("held_pulses", pulses, 1);
    check_outs();
    @(negedge clk); ready = 1'b0;
    repeat (2) @(posedge clk);

    // A second rise during busy is dropped, not queued.
    @(negedge clk);
    result = 16'd777; reminder = 16'd42; ready = 1'b1;
    set_exp(16'd777, 16'd42);
    pulses = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
      if (i == 9) ready = 1'b0;
      if (i == 10) begin
        ready = 1'b1; result = 16'd9999; reminder = 16'd1;
      end
    end
    chk("rise_in_busy_pulses", pulses, 1);
    chk("rise_in_busy_idle", 32'(busy), 0);
    check_outs();
    @(negedge clk); ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset 20 cycles into a conversion.
    @(negedge clk);
    result = 16'd4321; reminder = 16'd11; ready = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
      if (i == 2) ready = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    exp_res = '0; exp_rem = '0; exp_neg = 1'b0;
    check_outs();
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk); rst = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    check_outs();
    do_conv(16'h0010, 16'($urandom), 1'b0);
    chk("after_abort_res", 32'(res_bcd), 32'h00016);

    // ready already high when reset releases is not a trigger.
    @(negedge clk); rst = 1'b0; ready = 1'b1; result = 16'd5; reminder = 16'd5;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    exp_res = '0; exp_rem = '0; exp_neg = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (valid || busy) pulses++;
    end
    chk("rst_high_ready_activity", pulses, 0);
    check_outs();
    @(negedge clk); ready = 1'b0;
    @(posedge clk);
    do_conv(16'd300, 16'hFF00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdr_result_bcd.md
MDR_RESULT_BCD -- requirements
Module: mdr_result_bcd

Interface
REQ-001 Parameter DW, default 16 (from mdr_pkg), operand width; the block SHALL support only DW=16.
REQ-002 Parameter N_DIG, default 5 (from mdr_pkg), BCD digits per operand.
REQ-003 Port clk, input, 1: single clock; all state SHALL change only on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port ready, input, 1: SQRT Ready level; a conversion SHALL be triggered by its rising edge.
REQ-006 Port result, input, DW: unsigned root from SQRT Result.
REQ-007 Port reminder, input, DW: two's-complement remainder from SQRT Reminder.
REQ-008 Port res_bcd, output, 4*N_DIG: packed BCD of result, digit 0 in bits [3:0].
REQ-009 Port rem_bcd, output, 4*N_DIG: packed BCD of the remainder magnitude.
REQ-010 Port rem_neg, output, 1: remainder sign flag.
REQ-011 Port busy, output, 1: high while a conversion is in progress.
REQ-012 Port valid, output, 1: one-cycle pulse when new BCD outputs are presented.

Function
REQ-013 The block SHALL register ready into ready_q every cycle; a trigger SHALL be ready=1 and ready_q=0.
REQ-014 The FSM SHALL have exactly these states: IDLE, CONV_R, CONV_M, DONE.
REQ-015 IDLE: on a trigger, the block SHALL latch result and abs(reminder), latch sign=reminder[15], clear the iteration counter, and go to CONV_R.
REQ-016 CONV_R and CONV_M: each cycle SHALL perform one double-dabble step on a 36-bit shift register: add 3 to every BCD digit >=5, then shift left 1.
REQ-017 Each conversion state SHALL last exactly 16 cycles, counted by a 4-bit counter; on count 15 the FSM SHALL advance CONV_R->CONV_M or CONV_M->DONE.
REQ-018 DONE: res_bcd, rem_bcd and rem_neg SHALL update together, valid=1 for that cycle only, and the FSM SHALL return to IDLE.
REQ-019 Latency: valid SHALL be high in the 34th cycle after the edge that samples the trigger (1 + 16 + 16 + 1).
REQ-020 busy SHALL be 1 in CONV_R, CONV_M and DONE, and 0 in IDLE.
REQ-021 Triggers occurring while busy=1, including in DONE, SHALL be ignored and not queued.
REQ-022 ready held high SHALL produce exactly one conversion.
REQ-023 Negative remainder: the magnitude SHALL be the two's-complement negation; 0x8000 SHALL yield 32768 with rem_neg=1.
REQ-024 Outputs SHALL hold their last DONE values between conversions; changes on result and reminder after the latch SHALL have no effect.
REQ-025 Outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-026 With rst=0 at a clock edge: state SHALL be IDLE; res_bcd, rem_bcd, rem_neg, busy, valid, ready_q, the counter and the shift register SHALL all be 0.
REQ-027 Reset mid-conversion SHALL abort the conversion with no valid pulse; the first trigger after rst returns to 1 SHALL start normally.
REQ-028 If ready is already high when rst is released, that SHALL NOT count as a trigger until ready falls and rises again (ready_q is cleared in reset, so this requires ready_q to load 1 on the first post-reset cycle before IDLE evaluates a trigger).

Structure
REQ-029 mdr_pkg SHALL hold DW, N_DIG, ITER=16, and the FSM state enum type.
REQ-030 One combinational sub-module, bcd_add3_step (N_DIG-digit conditional add-3), SHALL be instantiated once and shared by CONV_R and CONV_M.

Verification
REQ-031 result=0x00FF, reminder=0x0003, ready rises -> after 34 cycles valid=1, res_bcd=0x00255, rem_bcd=0x00003, rem_neg=0.
REQ-032 result=0xFFFF, reminder=0xFFFB -> res_bcd=0x65535, rem_bcd=0x00005, rem_neg=1.
REQ-033 reminder=0x8000, result=0 -> rem_bcd=0x32768, rem_neg=1, res_bcd=0x00000.
REQ-034 ready held high for 100 cycles -> exactly one valid pulse; a second ready rise at cycle 10 of busy -> ignored and outputs unchanged.
REQ-035 rst=0 at cycle 20 of a conversion -> no valid pulse, all outputs 0; next trigger with result=0x0010 -> res_bcd=0x00016.
REQ-036 Inputs changed during busy -> outputs reflect the values latched at trigger.
